// File: rtl/mem_reader.sv
// Single-beat memory read master: issues one request per accepted start and
// reports a registered result byte, or aborts after TIMEOUT unacknowledged cycles.
module mem_reader #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  output logic       busy_o,
  output logic       mem_req_o,
  output logic [7:0] mem_addr_o,
  input  logic       mem_ack_i,
  input  logic [7:0] mem_data_i,
  output logic [7:0] data_out_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 8'h00;
      mem_addr_q <= 8'h00;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mem_addr_d = addr_i;
          cnt_d      = 8'h00;
          state_d    = StReq;
        end
      end
      StReq: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack_i) begin
          data_d  = mem_data_i;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'h01;
          if (cnt_d == TimeoutCnt) begin
            state_d = StErr;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are pure state decodes so reset clears them without a clock.
  assign busy_o     = (state_q != StIdle);
  assign mem_req_o  = (state_q == StReq);
  assign done_o     = (state_q == StDone);
  assign error_o    = (state_q == StErr);
  assign mem_addr_o = mem_addr_q;
  assign data_out_o = data_q;

endmodule

// File: tb/tb_mem_reader.sv
// Randomized bench for mem_reader: each read is described by its ack cycle and
// the expected cycle-by-cycle outputs are derived from that description.
module tb_mem_reader;

  localparam int unsigned TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] addr;
  logic       busy;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [7:0] data_out;
  logic       done;
  logic       error;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  exp_data = 8'h00;

  mem_reader #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .addr_i     (addr),
    .busy_o     (busy),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_ack_i  (mem_ack),
    .mem_data_i (mem_data),
    .data_out_o (data_out),
    .done_o     (done),
    .error_o    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".mem_req"},  32'(mem_req),  32'd0);
    chk({tag, ".done"},     32'(done),     32'd0);
    chk({tag, ".error"},    32'(error),    32'd0);
    chk({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // following idle cycle, so consecutive calls exercise back-to-back reads.
  // ack_cyc is the 1-based REQ cycle carrying the ack; > TIMEOUT means none.
  task automatic do_read(input logic [7:0] a, input int unsigned ack_cyc, input logic [7:0] d);
    bit          ok       = (ack_cyc <= TIMEOUT);
    int unsigned exit_cyc = ok ? ack_cyc : TIMEOUT;
    start = 1'b1;
    addr  = a;
    for (int unsigned k = 1; k <= exit_cyc; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      addr  = 8'($urandom);
      chk("req.mem_req",  32'(mem_req),  32'd1);
      chk("req.busy",     32'(busy),     32'd1);
      chk("req.mem_addr", 32'(mem_addr), 32'(a));
      chk("req.done",     32'(done),     32'd0);
      chk("req.error",    32'(error),    32'd0);
      chk("req.data_out", 32'(data_out), 32'(exp_data));
      mem_ack  = (k == ack_cyc);
      mem_data = (k == ack_cyc) ? d : 8'($urandom);
    end
    @(negedge clk);
    if (ok) exp_data = d;
    chk("end.done",     32'(done),     32'(ok));
    chk("end.error",    32'(error),    32'(!ok));
    chk("end.busy",     32'(busy),     32'd1);
    chk("end.mem_req",  32'(mem_req),  32'd0);
    chk("end.data_out", 32'(data_out), 32'(exp_data));
    start    = 1'b0;
    mem_ack  = 1'($urandom_range(0, 1));
    mem_data = 8'($urandom);
    @(negedge clk);
    chk_idle("post");
    mem_ack  = 1'($urandom_range(0, 1));
    mem_data = 8'($urandom);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    addr     = 8'h00;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    #2;
    chk_idle("reset");
    chk("reset.mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Ack on third REQ cycle, then a timeout, then an ack on the timeout cycle.
    do_read(8'h3C, 3, 8'hA5);
    do_read(8'h55, TIMEOUT + 1, 8'h00);
    do_read(8'h12, TIMEOUT, 8'h6E);
    do_read(8'hE0, 1, 8'h99);

    // Reset in the middle of a read drops everything at once.
    start = 1'b1;
    addr  = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_data = 8'h00;
    chk_idle("midrst");
    chk("midrst.mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      @(negedge clk);
      chk_idle("afterrst");
    end
    mem_ack = 1'b0;
    do_read(8'h01, 2, 8'h5A);

    for (int n = 0; n < 40; n++) begin
      int unsigned gap = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gap; g++) begin
        start = 1'b0;
        @(negedge clk);
        chk_idle("gap");
        mem_ack  = 1'($urandom_range(0, 1));
        mem_data = 8'($urandom);
      end
      do_read(8'($urandom), $urandom_range(1, TIMEOUT + 2), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
